// File: rtl/rv_plic_dispatch_pkg.sv
// Shared types and constants for the PLIC hardware dispatcher.
package rv_plic_dispatch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClaim,
        StDispatch,
        StWaitDone,
        StComplete,
        StSettle
    } dispatch_state_e;

    localparam int unsigned SettleCyclesDef = 2;
    localparam int unsigned DispCntW        = 16;
    localparam int unsigned ToCntW          = 8;

endpackage

// File: rtl/rv_plic_hw_dispatcher_if.sv
// Request handshake between the dispatcher (master) and the hardware engine (slave).
interface rv_plic_hw_dispatcher_if #(
    parameter int unsigned SrcW = 6
) ();
    logic            req_valid_o;
    logic [SrcW-1:0] req_id_o;
    logic            req_ready_i;
    logic            done_i;

    modport master (
        output req_valid_o,
        output req_id_o,
        input  req_ready_i,
        input  done_i
    );

    modport slave (
        input  req_valid_o,
        input  req_id_o,
        output req_ready_i,
        output done_i
    );
endinterface

// File: rtl/prim_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module prim_sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);
    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/rv_plic_hw_dispatcher.sv
// Claims a PLIC interrupt, hands its ID to a hardware engine, then completes it
// on done or timeout.
module rv_plic_hw_dispatcher
    import rv_plic_dispatch_pkg::*;
#(
    parameter  int unsigned NumSrc       = 32,
    parameter  int unsigned TimeoutW     = 16,
    parameter  int unsigned SettleCycles = SettleCyclesDef,
    localparam int unsigned SRCW         = $clog2(NumSrc + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic [TimeoutW-1:0]       timeout_i,
    input  logic                      irq_i,
    input  logic [SRCW-1:0]           irq_id_i,
    output logic                      claim_o,
    output logic                      complete_o,
    output logic [SRCW-1:0]           complete_id_o,
    rv_plic_hw_dispatcher_if.master   req_if,
    output logic                      busy_o,
    output logic                      timeout_o,
    output logic [DispCntW-1:0]       dispatch_cnt_o,
    output logic [ToCntW-1:0]         timeout_cnt_o
);
    // One extra bit keeps the width legal when SettleCycles is 0.
    localparam int unsigned SettleW = $clog2(SettleCycles + 2);

    dispatch_state_e     state_d, state_q;
    logic [SRCW-1:0]     cur_id_d, cur_id_q;
    logic [TimeoutW-1:0] timer_d, timer_q;
    logic [SettleW-1:0]  settle_d, settle_q;
    logic                req_valid;
    logic                disp_inc;
    logic                to_inc;

    always_comb begin
        state_d    = state_q;
        cur_id_d   = cur_id_q;
        timer_d    = timer_q;
        settle_d   = settle_q;
        claim_o    = 1'b0;
        complete_o = 1'b0;
        req_valid  = 1'b0;
        timeout_o  = 1'b0;
        disp_inc   = 1'b0;
        to_inc     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en_i && irq_i && (irq_id_i != '0)) begin
                    state_d = StClaim;
                end
            end
            StClaim: begin
                claim_o  = 1'b1;
                cur_id_d = irq_id_i;
                state_d  = StDispatch;
            end
            StDispatch: begin
                req_valid = 1'b1;
                if (req_if.req_ready_i) begin
                    timer_d  = timeout_i;
                    disp_inc = 1'b1;
                    state_d  = StWaitDone;
                end
            end
            StWaitDone: begin
                // done beats a simultaneous expiry; a timer of 0 never expires.
                if (req_if.done_i) begin
                    state_d = StComplete;
                end else if (timer_q == TimeoutW'(1)) begin
                    timeout_o = 1'b1;
                    to_inc    = 1'b1;
                    state_d   = StComplete;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TimeoutW'(1);
                end
            end
            StComplete: begin
                complete_o = 1'b1;
                settle_d   = SettleW'(SettleCycles);
                state_d    = StSettle;
            end
            StSettle: begin
                if (settle_q <= SettleW'(1)) begin
                    settle_d = '0;
                    state_d  = StIdle;
                end else begin
                    settle_d = settle_q - SettleW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cur_id_q <= '0;
            timer_q  <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            timer_q  <= timer_d;
            settle_q <= settle_d;
        end
    end

    assign req_if.req_valid_o = req_valid;
    assign req_if.req_id_o    = cur_id_q;
    assign complete_id_o      = cur_id_q;
    assign busy_o             = (state_q != StIdle);

    prim_sat_counter #(
        .Width (DispCntW)
    ) u_dispatch_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (disp_inc),
        .cnt_o  (dispatch_cnt_o)
    );

    prim_sat_counter #(
        .Width (ToCntW)
    ) u_timeout_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (to_inc),
        .cnt_o  (timeout_cnt_o)
    );
endmodule

// File: tb/tb_rv_plic_hw_dispatcher.sv
// Self-checking bench for rv_plic_hw_dispatcher: vector table plus scoreboard of completions.
module tb_rv_plic_hw_dispatcher;
    import rv_plic_dispatch_pkg::*;

    localparam int unsigned SRCW         = 6;
    localparam int unsigned SettleCycles = 2;

    logic            clk_i  = 1'b0;
    logic            rst_ni = 1'b1;
    logic            en_i;
    logic [15:0]     timeout_i;
    logic            irq_i;
    logic [SRCW-1:0] irq_id_i;
    logic            claim_o;
    logic            complete_o;
    logic [SRCW-1:0] complete_id_o;
    logic            busy_o;
    logic            timeout_o;
    logic [15:0]     dispatch_cnt_o;
    logic [7:0]      timeout_cnt_o;
    logic            sc_inc;
    logic [3:0]      sc_cnt;

    rv_plic_hw_dispatcher_if #(.SrcW(SRCW)) req_if ();

    rv_plic_hw_dispatcher #(
        .NumSrc       (32),
        .TimeoutW     (16),
        .SettleCycles (SettleCycles)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .en_i           (en_i),
        .timeout_i      (timeout_i),
        .irq_i          (irq_i),
        .irq_id_i       (irq_id_i),
        .claim_o        (claim_o),
        .complete_o     (complete_o),
        .complete_id_o  (complete_id_o),
        .req_if         (req_if),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o),
        .dispatch_cnt_o (dispatch_cnt_o),
        .timeout_cnt_o  (timeout_cnt_o)
    );

    prim_sat_counter #(.Width(4)) u_sc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (sc_inc),
        .cnt_o  (sc_cnt)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [SRCW-1:0] id;
        logic            to;
    } exp_t;

    typedef struct {
        logic            en;
        logic [SRCW-1:0] id;
        logic [15:0]     tmo;
        int              rdy;
        int              dn;
        logic            claim;
        logic            to;
    } vec_t;

    exp_t sb[$];
    vec_t vt[8];

    int   vectors, miscompares;
    int   cyc_n, cmp_n, cmp_total;
    int   exp_disp, exp_tocnt;
    logic to_seen;
    logic s_claim, s_valid, s_cmp, s_to, s_busy;
    logic [SRCW-1:0] s_rid, s_cid;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, pop the scoreboard on complete_o,
    // return just after the next rising edge so the caller can drive the next cycle.
    task automatic cyc();
        exp_t e;
        @(negedge clk_i);
        cyc_n++;
        s_claim = claim_o;
        s_valid = req_if.req_valid_o;
        s_rid   = req_if.req_id_o;
        s_cmp   = complete_o;
        s_cid   = complete_id_o;
        s_to    = timeout_o;
        s_busy  = busy_o;
        if (s_to) to_seen = 1'b1;
        if (s_cmp) begin
            cmp_total++;
            cmp_n = cyc_n;
            if (sb.size() == 0) begin
                chk("unexpected_complete", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("complete_id", 32'(s_cid), 32'(e.id));
                chk("timeout_pulse", 32'(to_seen), 32'(e.to));
            end
            to_seen = 1'b0;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_irq(input logic [SRCW-1:0] id, input logic [15:0] tmo, input int rdy_dly,
                           input int done_dly, input logic exp_to, input logic hold);
        exp_t e;
        int   acc, lat;
        logic got;
        e.id = id;
        e.to = exp_to;
        sb.push_back(e);
        en_i = 1'b1;
        irq_i = 1'b1;
        irq_id_i = id;
        timeout_i = tmo;
        req_if.req_ready_i = 1'b0;
        req_if.done_i = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            cyc();
            got = s_claim;
        end
        chk("claim_seen", 32'(got), 32'd1);
        if (!hold) irq_i = 1'b0;
        for (int k = 0; k < rdy_dly; k++) begin
            cyc();
            chk("req_valid_held", 32'(s_valid), 32'd1);
            chk("req_id_held", 32'(s_rid), 32'(id));
        end
        req_if.req_ready_i = 1'b1;
        cyc();
        chk("req_valid", 32'(s_valid), 32'd1);
        chk("req_id", 32'(s_rid), 32'(id));
        acc = cyc_n;
        req_if.req_ready_i = 1'b0;
        if (done_dly > 0 && (tmo == 0 || done_dly <= int'(tmo))) lat = done_dly + 1;
        else lat = int'(tmo) + 1;
        got = 1'b0;
        for (int k = 1; k <= 300 && !got; k++) begin
            req_if.done_i = (k == done_dly);
            cyc();
            got = s_cmp;
        end
        req_if.done_i = 1'b0;
        chk("complete_seen", 32'(got), 32'd1);
        chk("complete_latency", 32'(cmp_n - acc), 32'(lat));
        for (int k = 0; k < SettleCycles; k++) begin
            cyc();
            chk("settle_no_claim", 32'(s_claim), 32'd0);
            chk("settle_busy", 32'(s_busy), 32'd1);
        end
        if (exp_disp < 65535) exp_disp++;
        if (exp_to && exp_tocnt < 255) exp_tocnt++;
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc_n = 0; cmp_n = 0; cmp_total = 0;
        exp_disp = 0; exp_tocnt = 0; to_seen = 1'b0;
        en_i = 1'b0; irq_i = 1'b0; irq_id_i = '0; timeout_i = '0; sc_inc = 1'b0;
        req_if.req_ready_i = 1'b0; req_if.done_i = 1'b0;

        //           en    id  tmo rdy dn  claim to
        vt[0] = '{1'b1, 6'd5,  16'd0,  0,  3, 1'b1, 1'b0};
        vt[1] = '{1'b1, 6'd10, 16'd10, 0, -1, 1'b1, 1'b1};
        vt[2] = '{1'b1, 6'd3,  16'd4,  0,  4, 1'b1, 1'b0};
        vt[3] = '{1'b1, 6'd31, 16'd5,  2,  2, 1'b1, 1'b0};
        vt[4] = '{1'b1, 6'd1,  16'd1,  1, -1, 1'b1, 1'b1};
        vt[5] = '{1'b0, 6'd9,  16'd0,  0,  1, 1'b0, 1'b0};
        vt[6] = '{1'b1, 6'd0,  16'd0,  0,  1, 1'b0, 1'b0};
        vt[7] = '{1'b1, 6'd32, 16'd3,  3,  1, 1'b1, 1'b0};

        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_claim", 32'(claim_o), 32'd0);
        chk("rst_complete", 32'(complete_o), 32'd0);
        chk("rst_req_valid", 32'(req_if.req_valid_o), 32'd0);
        chk("rst_req_id", 32'(req_if.req_id_o), 32'd0);
        chk("rst_disp_cnt", 32'(dispatch_cnt_o), 32'd0);
        chk("rst_to_cnt", 32'(timeout_cnt_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 8; i++) begin
            if (vt[i].claim) begin
                run_irq(vt[i].id, vt[i].tmo, vt[i].rdy, vt[i].dn, vt[i].to, 1'b0);
            end else begin
                en_i = vt[i].en;
                irq_i = 1'b1;
                irq_id_i = vt[i].id;
                for (int k = 0; k < 6; k++) begin
                    req_if.done_i = (k == 2);
                    cyc();
                    chk("no_claim", 32'(s_claim), 32'd0);
                    chk("idle_not_busy", 32'(s_busy), 32'd0);
                end
                req_if.done_i = 1'b0;
                irq_i = 1'b0;
                en_i = 1'b1;
            end
            chk("dispatch_cnt", 32'(dispatch_cnt_o), 32'(exp_disp));
            chk("timeout_cnt", 32'(timeout_cnt_o), 32'(exp_tocnt));
        end

        // Backpressure with irq held: a second claim of ID 7 follows only after settling.
        run_irq(6'd7, 16'd0, 20, 2, 1'b0, 1'b1);
        run_irq(6'd7, 16'd0, 0, 1, 1'b0, 1'b0);
        chk("bp_dispatch_cnt", 32'(dispatch_cnt_o), 32'(exp_disp));

        // Reset while waiting for done: no complete may follow.
        en_i = 1'b1; irq_i = 1'b1; irq_id_i = 6'd12; timeout_i = '0;
        req_if.req_ready_i = 1'b1;
        repeat (3) cyc();
        irq_i = 1'b0;
        req_if.req_ready_i = 1'b0;
        repeat (3) cyc();
        chk("wait_busy", 32'(busy_o), 32'd1);
        chk("wait_no_valid", 32'(req_if.req_valid_o), 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy_o), 32'd0);
        chk("async_rst_complete", 32'(complete_o), 32'd0);
        chk("async_rst_req_id", 32'(req_if.req_id_o), 32'd0);
        chk("async_rst_cid", 32'(complete_id_o), 32'd0);
        chk("async_rst_disp_cnt", 32'(dispatch_cnt_o), 32'd0);
        chk("async_rst_to_cnt", 32'(timeout_cnt_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        exp_disp = 0; exp_tocnt = 0; to_seen = 1'b0;
        @(posedge clk_i);
        #1;
        begin
            int cmp_before;
            cmp_before = cmp_total;
            for (int k = 0; k < 10; k++) begin
                req_if.done_i = (k % 3 == 0);
                cyc();
            end
            req_if.done_i = 1'b0;
            chk("post_rst_no_complete", 32'(cmp_total), 32'(cmp_before));
            chk("post_rst_idle", 32'(busy_o), 32'd0);
        end

        // Timeout counter saturation.
        for (int i = 0; i < 260; i++) begin
            run_irq(SRCW'((i % 32) + 1), 16'd1, 0, -1, 1'b1, 1'b0);
        end
        chk("to_cnt_saturated", 32'(timeout_cnt_o), 32'd255);
        chk("disp_cnt_after_sat", 32'(dispatch_cnt_o), 32'd260);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Standalone narrow counter saturation.
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        sc_inc = 1'b1;
        repeat (7) cyc();
        chk("sat_cnt_mid", 32'(sc_cnt), 32'd7);
        repeat (13) cyc();
        chk("sat_cnt_top", 32'(sc_cnt), 32'd15);
        sc_inc = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
